// File: rtl/line_mem_responder.sv
// line_mem_responder
//   Memory-side responder for the CPU line-request interface. It holds a
//   byte-addressed backing store and services one read-line or write request
//   at a time. The response comes a fixed LATENCY cycles after the request is
//   accepted.
//
// Ports
//   clk_i            clock
//   rst_i            asynchronous active-high reset (store contents are kept)
//   rd_req_valid_i   read-line request strobe
//   wr_req_valid_i   write request strobe (wins over a simultaneous read)
//   req_is_instr_i   request is an instruction fetch
//   address_i        physical byte address (taken modulo MEM_SIZE)
//   wr_data_i        write data, little-endian, byte 0 in bits [7:0]
//   access_size_i    write size: 00 byte, 10 word, 11 line, 01 reserved
//   busy_o           a request is in flight; new strobes are ignored
//   data_valid_o     one-cycle read response strobe
//   data_is_instr_o  instruction-fetch flag of the read being answered
//   data_o           read line data, held until the next read response
//   write_done_o     one-cycle write completion strobe
//   debug_mem_o      live view of the backing store
module line_mem_responder #(
  parameter int MEM_SIZE   = 16384,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16,
  parameter int LATENCY    = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    rd_req_valid_i,
  input  logic                    wr_req_valid_i,
  input  logic                    req_is_instr_i,
  input  logic [ADDR_WIDTH-1:0]   address_i,
  input  logic [LINE_BYTES*8-1:0] wr_data_i,
  input  logic [1:0]              access_size_i,
  output logic                    busy_o,
  output logic                    data_valid_o,
  output logic                    data_is_instr_o,
  output logic [LINE_BYTES*8-1:0] data_o,
  output logic                    write_done_o,
  output logic [7:0]              debug_mem_o [MEM_SIZE]
);

  localparam int MEM_AW = $clog2(MEM_SIZE);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int LIDX_W = MEM_AW - OFF_W;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_LINE = 2'b11;

  logic [1:0]        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [MEM_AW-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic              instr_q;
  logic              is_write_q;

  logic [7:0]        mem [MEM_SIZE];

  logic              accept;
  logic              load_rd;
  logic [LIDX_W-1:0] rd_line;
  logic [LINE_W-1:0] rd_line_data;
  logic [OFF_W-1:0]  wr_off;
  logic [LINE_BYTES-1:0] wr_byte_en;
  logic [7:0]        wr_byte_val [LINE_BYTES];

  // Address bits above the store size only select aliases of the same bytes.
  if (ADDR_WIDTH > MEM_AW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^address_i[ADDR_WIDTH-1:MEM_AW];
  end

  assign accept = (state_q == ST_IDLE) && (rd_req_valid_i || wr_req_valid_i);

  // Request sequencing: IDLE accepts, WAIT counts the latency down, RESP is
  // the single cycle in which the response strobe is shown. The counter is
  // loaded with LATENCY-1 so that RESP starts LATENCY-1 edges after the
  // accepting edge and the strobe is seen at the LATENCY-th edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cnt_q   <= LAT_M1;
            state_q <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Request capture. A write strobe outranks a simultaneous read strobe, and
  // the dropped read leaves no trace.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      instr_q    <= 1'b0;
      is_write_q <= 1'b0;
    end else if (accept) begin
      addr_q     <= address_i[MEM_AW-1:0];
      wdata_q    <= wr_data_i;
      size_q     <= access_size_i;
      instr_q    <= req_is_instr_i;
      is_write_q <= wr_req_valid_i;
    end
  end

  // The read line is loaded into data_o on the edge that enters RESP. With a
  // one-cycle latency that edge is the accepting edge itself, so the line is
  // then taken from the live address instead of the captured one.
  always_comb begin
    rd_line      = addr_q[MEM_AW-1:OFF_W];
    load_rd      = 1'b0;
    rd_line_data = '0;
    if (state_q == ST_IDLE) begin
      rd_line = address_i[MEM_AW-1:OFF_W];
      load_rd = (LATENCY == 1) && rd_req_valid_i && !wr_req_valid_i;
    end else if (state_q == ST_WAIT) begin
      load_rd = (cnt_q == CNT_W'(1)) && !is_write_q;
    end
    for (int i = 0; i < LINE_BYTES; i++) begin
      rd_line_data[i*8 +: 8] = mem[{rd_line, OFF_W'(i)}];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o <= '0;
    end else if (load_rd) begin
      data_o <= rd_line_data;
    end
  end

  // Every write size is handled as a per-byte enable over the addressed line.
  // A word covers the aligned 4-byte group holding the address, and a byte
  // covers only the addressed offset. The reserved size enables nothing.
  assign wr_off = addr_q[OFF_W-1:0];

  always_comb begin
    for (int i = 0; i < LINE_BYTES; i++) begin
      wr_byte_en[i]  = 1'b0;
      wr_byte_val[i] = 8'h00;
      case (size_q)
        SZ_BYTE: begin
          wr_byte_en[i]  = (OFF_W'(i) == wr_off);
          wr_byte_val[i] = wdata_q[7:0];
        end
        SZ_WORD: begin
          wr_byte_en[i]  = ((OFF_W'(i) >> 2) == (wr_off >> 2));
          wr_byte_val[i] = wdata_q[(i % 4)*8 +: 8];
        end
        SZ_LINE: begin
          wr_byte_en[i]  = 1'b1;
          wr_byte_val[i] = wdata_q[i*8 +: 8];
        end
        default: begin
          wr_byte_en[i] = 1'b0;
        end
      endcase
    end
  end

  // The backing store is not reset. A write commits on the edge that ends
  // RESP. Reset forces IDLE asynchronously, so an aborted write never lands.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_RESP && is_write_q) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        if (wr_byte_en[i]) begin
          mem[{addr_q[MEM_AW-1:OFF_W], OFF_W'(i)}] <= wr_byte_val[i];
        end
      end
    end
  end

  assign debug_mem_o = mem;

  // The strobes are decoded from state, so reset clears them immediately.
  assign busy_o          = (state_q != ST_IDLE);
  assign data_valid_o    = (state_q == ST_RESP) && !is_write_q;
  assign write_done_o    = (state_q == ST_RESP) && is_write_q;
  assign data_is_instr_o = data_valid_o && instr_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder
//   Self-checking bench for line_mem_responder (LATENCY=5, 16-byte lines,
//   16 KiB store). A request-level model predicts busy, the strobes and the
//   read data every cycle. Directed sequences add literal expectations for
//   timing, store contents, write priority, address wrap and reset abort.
module tb_line_mem_responder;

  localparam int MEM_SIZE   = 16384;
  localparam int ADDR_WIDTH = 32;
  localparam int LINE_BYTES = 16;
  localparam int LATENCY    = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rd_req_valid = 1'b0;
  logic         wr_req_valid = 1'b0;
  logic         req_is_instr = 1'b0;
  logic [31:0]  address = '0;
  logic [127:0] wr_data = '0;
  logic [1:0]   access_size = '0;
  logic         busy_o;
  logic         data_valid_o;
  logic         data_is_instr_o;
  logic [127:0] data_o;
  logic         write_done_o;
  logic [7:0]   debug_mem [MEM_SIZE];

  line_mem_responder #(
    .MEM_SIZE  (MEM_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH),
    .LINE_BYTES(LINE_BYTES),
    .LATENCY   (LATENCY)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rd_req_valid_i (rd_req_valid),
    .wr_req_valid_i (wr_req_valid),
    .req_is_instr_i (req_is_instr),
    .address_i      (address),
    .wr_data_i      (wr_data),
    .access_size_i  (access_size),
    .busy_o         (busy_o),
    .data_valid_o   (data_valid_o),
    .data_is_instr_o(data_is_instr_o),
    .data_o         (data_o),
    .write_done_o   (write_done_o),
    .debug_mem_o    (debug_mem)
  );

  always #5 clk = ~clk;

  int n_vectors     = 0;
  int n_miscompares = 0;
  bit checking      = 1'b0;
  int dv_pulses     = 0;
  int wd_pulses     = 0;

  // Model state: one pending request and the edge number of its response.
  logic [7:0]   model_mem [MEM_SIZE];
  int           cyc       = 0;
  int           resp_edge = 0;
  bit           pending   = 1'b0;
  bit           p_write   = 1'b0;
  bit           p_instr   = 1'b0;
  logic [31:0]  p_addr    = '0;
  logic [127:0] p_data    = '0;
  logic [1:0]   p_size    = '0;
  logic         exp_busy  = 1'b0;
  logic         exp_dv    = 1'b0;
  logic         exp_wd    = 1'b0;
  logic         exp_instr = 1'b0;
  logic [127:0] exp_data  = '0;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkOutput(name, {127'b0, actual}, {127'b0, expected});
  endtask

  task automatic checkByte(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkOutput(name, {120'b0, actual}, {120'b0, expected});
  endtask

  function automatic logic [127:0] model_line(input logic [31:0] addr);
    logic [127:0] r;
    int unsigned  base;
    base = (addr % 32'(MEM_SIZE)) & ~32'(LINE_BYTES - 1);
    for (int i = 0; i < LINE_BYTES; i++) r[i*8 +: 8] = model_mem[base + i];
    return r;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [127:0] d, input logic [1:0] sz);
    int unsigned a;
    a = addr % 32'(MEM_SIZE);
    case (sz)
      2'b00: model_mem[a] = d[7:0];
      2'b10: for (int j = 0; j < 4; j++) model_mem[(a & ~32'd3) + j] = d[j*8 +: 8];
      2'b11: for (int j = 0; j < LINE_BYTES; j++)
               model_mem[(a & ~32'(LINE_BYTES - 1)) + j] = d[j*8 +: 8];
      default: ;
    endcase
  endtask

  // Request-level model: a request accepted at edge N is answered in the
  // cycle between edges N+LATENCY-1 and N+LATENCY, and nothing is accepted
  // again until edge N+LATENCY+1.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      pending  = 1'b0;
      exp_data = '0;
    end else if (pending) begin
      if (cyc == resp_edge) begin
        if (p_write) model_write(p_addr, p_data, p_size);
        pending = 1'b0;
      end
    end else if (rd_req_valid || wr_req_valid) begin
      pending   = 1'b1;
      p_write   = wr_req_valid;
      p_instr   = req_is_instr;
      p_addr    = address;
      p_data    = wr_data;
      p_size    = access_size;
      resp_edge = cyc + LATENCY;
    end
    exp_busy  = pending;
    exp_dv    = pending && !p_write && (cyc == resp_edge - 1);
    exp_wd    = pending && p_write && (cyc == resp_edge - 1);
    exp_instr = exp_dv && p_instr;
    if (exp_dv) exp_data = model_line(p_addr);
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (checking) begin
      if (rst) begin
        checkBit("cyc_busy_rst", busy_o, 1'b0);
        checkBit("cyc_dv_rst", data_valid_o, 1'b0);
        checkBit("cyc_wd_rst", write_done_o, 1'b0);
        checkBit("cyc_instr_rst", data_is_instr_o, 1'b0);
        checkOutput("cyc_data_rst", data_o, 128'h0);
      end else begin
        checkBit("cyc_busy", busy_o, exp_busy);
        checkBit("cyc_dv", data_valid_o, exp_dv);
        checkBit("cyc_wd", write_done_o, exp_wd);
        checkBit("cyc_instr", data_is_instr_o, exp_instr);
        checkOutput("cyc_data", data_o, exp_data);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (data_valid_o === 1'b1) dv_pulses++;
    if (write_done_o === 1'b1) wd_pulses++;
  end

  // Drives one request for one cycle; returns at the negedge after the
  // sampling edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic instr,
                               input logic [31:0] addr, input logic [127:0] data,
                               input logic [1:0] size);
    @(negedge clk);
    rd_req_valid = rd;
    wr_req_valid = wr;
    req_is_instr = instr;
    address      = addr;
    wr_data      = data;
    access_size  = size;
    @(negedge clk);
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    req_is_instr = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy_o !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkBit("wait_idle", busy_o, 1'b0);
    #1;
  endtask

  task automatic writeLine(input logic [31:0] addr, input logic [127:0] data);
    applyStimulus(1'b0, 1'b1, 1'b0, addr, data, 2'b11);
    waitIdle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dv0;
    int wd0;

    // Reset values.
    repeat (3) @(negedge clk);
    checkBit("reset_busy", busy_o, 1'b0);
    checkBit("reset_dv", data_valid_o, 1'b0);
    checkBit("reset_wd", write_done_o, 1'b0);
    checkOutput("reset_data", data_o, 128'h0);
    rst = 1'b0;
    checking = 1'b1;

    // Instruction line read with exact strobe timing.
    writeLine(32'h1000, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h1004, 128'h0, 2'b00);
    checkBit("rd1_busy_first", busy_o, 1'b1);
    checkBit("rd1_dv_first", data_valid_o, 1'b0);
    repeat (3) @(negedge clk);
    checkBit("rd1_dv_before", data_valid_o, 1'b0);
    @(negedge clk);
    checkBit("rd1_dv", data_valid_o, 1'b1);
    checkBit("rd1_instr", data_is_instr_o, 1'b1);
    checkBit("rd1_busy_resp", busy_o, 1'b1);
    checkOutput("rd1_data", data_o, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    @(negedge clk);
    checkBit("rd1_dv_after", data_valid_o, 1'b0);
    checkBit("rd1_instr_after", data_is_instr_o, 1'b0);
    checkBit("rd1_busy_after", busy_o, 1'b0);
    checkOutput("rd1_data_hold", data_o, 128'h0F0E0D0C_0B0A0908_07060504_03020100);

    // Word write at an unaligned address lands on the aligned word.
    writeLine(32'h2000, {16{8'h55}});
    wd0 = wd_pulses;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h2006, 128'hCAFEBABE_CAFEBABE_CAFEBABE_DEADBEEF, 2'b10);
    waitIdle();
    checkOutput("word_done_count", 128'(wd_pulses - wd0), 128'd1);
    checkByte("word_mem_2004", debug_mem[16'h2004], 8'hEF);
    checkByte("word_mem_2005", debug_mem[16'h2005], 8'hBE);
    checkByte("word_mem_2006", debug_mem[16'h2006], 8'hAD);
    checkByte("word_mem_2007", debug_mem[16'h2007], 8'hDE);
    checkByte("word_mem_2008", debug_mem[16'h2008], 8'h55);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h2000, 128'h0, 2'b00);
    waitIdle();
    checkOutput("word_readback", data_o, 128'h55555555_55555555_DEADBEEF_55555555);

    // Byte write, line write and reserved size.
    writeLine(32'h3000, {16{8'h33}});
    wd0 = wd_pulses;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h3003, 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A69A5, 2'b00);
    waitIdle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h3010, {16{8'h11}}, 2'b11);
    waitIdle();
    checkOutput("bytline_done_count", 128'(wd_pulses - wd0), 128'd2);
    checkByte("byte_mem_3003", debug_mem[16'h3003], 8'hA5);
    checkByte("byte_mem_3000", debug_mem[16'h3000], 8'h33);
    checkByte("byte_mem_3002", debug_mem[16'h3002], 8'h33);
    checkByte("byte_mem_3004", debug_mem[16'h3004], 8'h33);
    checkByte("line_mem_3010", debug_mem[16'h3010], 8'h11);
    checkByte("line_mem_301f", debug_mem[16'h301F], 8'h11);
    wd0 = wd_pulses;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h3000, {16{8'hEE}}, 2'b01);
    waitIdle();
    checkOutput("rsvd_done_count", 128'(wd_pulses - wd0), 128'd1);
    checkByte("rsvd_mem_3000", debug_mem[16'h3000], 8'h33);
    checkByte("rsvd_mem_300f", debug_mem[16'h300F], 8'h33);

    // Read strobe while a write is pending is ignored.
    dv0 = dv_pulses;
    wd0 = wd_pulses;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0100, 128'h99, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0100, 128'h0, 2'b00);
    waitIdle();
    checkBit("busy_drop_idle", busy_o, 1'b0);
    repeat (LATENCY + 2) @(negedge clk);
    #1;
    checkOutput("busy_drop_wd", 128'(wd_pulses - wd0), 128'd1);
    checkOutput("busy_drop_dv", 128'(dv_pulses - dv0), 128'd0);
    checkByte("busy_drop_mem", debug_mem[16'h0100], 8'h99);

    // Simultaneous read and write: the write wins.
    dv0 = dv_pulses;
    wd0 = wd_pulses;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0040, 128'h77, 2'b00);
    waitIdle();
    repeat (LATENCY + 2) @(negedge clk);
    #1;
    checkOutput("both_wd", 128'(wd_pulses - wd0), 128'd1);
    checkOutput("both_dv", 128'(dv_pulses - dv0), 128'd0);
    checkByte("both_mem_40", debug_mem[16'h0040], 8'h77);

    // Address wrap: 0x4010 aliases line 0x0010.
    writeLine(32'h0010, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h4010, 128'h0, 2'b00);
    waitIdle();
    checkOutput("wrap_data", data_o, 128'h00112233_44556677_8899AABB_CCDDEEFF);

    // Reset three edges into a word write aborts it.
    writeLine(32'h0500, {16{8'hAA}});
    wd0 = wd_pulses;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0500, 128'h0BADF00D_0BADF00D_0BADF00D_12345678, 2'b10);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkBit("abort_busy", busy_o, 1'b0);
    checkBit("abort_dv", data_valid_o, 1'b0);
    checkBit("abort_wd", write_done_o, 1'b0);
    checkOutput("abort_data", data_o, 128'h0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (LATENCY + 2) @(negedge clk);
    #1;
    checkOutput("abort_no_done", 128'(wd_pulses - wd0), 128'd0);
    checkByte("abort_mem_500", debug_mem[16'h0500], 8'hAA);
    checkByte("abort_mem_503", debug_mem[16'h0503], 8'hAA);
    dv0 = dv_pulses;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0500, 128'h0, 2'b00);
    waitIdle();
    checkOutput("post_rst_dv", 128'(dv_pulses - dv0), 128'd1);
    checkOutput("post_rst_data", data_o, {16{8'hAA}});

    repeat (2) @(negedge clk);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Memory-side responder for the CPU line-request interface: rd_req_valid/wr_req_valid, address, wr_data and access_size in; data_valid, data_is_instr, line data and write_done out.
- Holds a byte-addressed backing array and services one request at a time after a programmable fixed latency.
- Sits between the CPU/cache request port and the system. It is the synthesizable, latency-accurate memory for core simulation and the CPI testbench.

Parameters:
MEM_SIZE, 16384, backing store size in bytes (power of two)
ADDR_WIDTH, 32, physical request address width
LINE_BYTES, 16, cache line size in bytes (power of two, at least 4)
LATENCY, 5, cycles from request acceptance to response (at least 1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
rd_req_valid_i  in  1  read-line request strobe
wr_req_valid_i  in  1  write request strobe
req_is_instr_i  in  1  request is an instruction fetch
address_i  in  ADDR_WIDTH  physical byte address
wr_data_i  in  LINE_BYTES*8  write data, little-endian, byte 0 in bits [7:0]
access_size_i  in  2  write size: 00 byte, 10 word, 11 line (01 reserved)
busy_o  out  1  a request is in flight; new strobes are ignored
data_valid_o  out  1  one-cycle read response strobe
data_is_instr_o  out  1  echo of req_is_instr_i for the response
data_o  out  LINE_BYTES*8  read line data
write_done_o  out  1  one-cycle write completion strobe
debug_mem_o  out  MEM_SIZE x 8  live view of the backing store

Behaviour:
- Reset (asynchronous, rst_i=1):
  - FSM goes to IDLE; busy_o, data_valid_o, data_is_instr_o and write_done_o go to 0; data_o goes to 0; the latency counter clears.
  - Backing store contents are not cleared by reset. They are preloaded by the bench or $readmemh.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a rising edge with rd_req_valid_i or wr_req_valid_i high, latch address, wr_data, size, is_instr and operation; load counter = LATENCY-1; go to WAIT (RESP directly if LATENCY=1); busy_o=1 from the next cycle.
  - If both strobes are high, the write wins and the read is dropped. No response is ever produced for the dropped read.
- WAIT: decrement the counter each cycle; move to RESP when it reaches 0.
- RESP (exactly one cycle):
  - Read: data_o = LINE_BYTES bytes starting at the line-aligned latched address (low log2(LINE_BYTES) bits cleared). data_valid_o=1 and data_is_instr_o = latched flag.
  - Write: commit to the store on this cycle's edge; write_done_o=1.
    - byte: wr_data[7:0] goes to addr.
    - word: wr_data[31:0] goes to addr with the low 2 bits cleared, little-endian.
    - line: the full wr_data goes to the line-aligned addr.
    - reserved size 01: no store change, but write_done_o still pulses.
  - Next state is IDLE; busy_o falls with the strobe.
- Timing: a request sampled at edge N produces its strobe high in the cycle after edge N+LATENCY-1, i.e. visible at edge N+LATENCY.
- Strobes asserted while busy_o=1, including during RESP, are ignored, not queued. The requester must re-issue them in IDLE.
- data_o holds its last read value until the next read response. data_is_instr_o is 0 whenever data_valid_o is 0.
- Address wrap: the byte index is the address modulo MEM_SIZE. A line never straddles the wrap because of alignment.
- Reset mid-operation: the in-flight request is aborted, no strobe is produced and the store is untouched.
- debug_mem_o reflects a write in the cycle after its RESP edge.

Test Plan:
- Preload bytes 0x1000..0x100F with 0x00..0x0F, LATENCY=5; read at 0x1004 with is_instr=1 at edge 10 -> data_valid_o and data_is_instr_o high only at edge 15, data_o=0x0F0E...0100, busy_o high at edges 11-15.
- Word write 0xDEADBEEF at 0x2006 -> write_done_o at +5; bytes 0x2004..0x2007 = EF BE AD DE; a following line read of 0x2000 returns them in data_o bits [63:32].
- Byte write 0xA5 at 0x3003, then line write of an all-0x11 line at 0x3010 -> 0x3003=0xA5, 0x3000..0x3002 unchanged, 0x3010..0x301F=0x11; two write_done_o pulses, one per request.
- Read strobe pulsed at +2 during a pending write at 0x100 -> ignored: exactly one write_done_o, no data_valid_o; busy_o=0 the cycle after the done pulse.
- rd and wr strobes together at 0x40 (byte 0x77) -> only write_done_o pulses and mem[0x40]=0x77. Address 0x4010 with MEM_SIZE=0x4000 reads line 0x0010.
- rst_i asserted at +3 of a word write at 0x500 -> outputs 0 immediately (asynchronously), mem[0x500..0x503] unchanged, no strobe. The next read after reset returns normally after LATENCY cycles.
